// File: rtl/sincos_pkg.sv
// Shared constants and types for the iterative sin/cos CORDIC core.
// x/y use Q2.30 and the angle z uses Q3.29. All are held in 32-bit registers.
package sincos_pkg;

  localparam int unsigned XY_FW   = 32;
  localparam int unsigned XY_FRAC = 30;
  localparam int unsigned Z_FRAC  = 29;

  typedef enum logic [2:0] {StIdle, StLoad, StIter, StPack, StDone} state_e;

  localparam logic [31:0] CORDIC_K     = 32'h26DD3B6A;  // 0.6072529, Q2.30
  localparam logic [31:0] PI_Q329      = 32'h6487ED51;
  localparam logic [31:0] HALF_PI_Q329 = 32'h3243F6A9;

  // float32(pi/2) and float32(pi) both round above the true values. The range limits use
  // their exact Q3.29 images so that the float32 constants themselves stay in range.
  localparam logic [31:0] HALF_PI_F32_Q329 = 32'h3243F6C0;
  localparam logic [31:0] PI_F32_Q329      = 32'h6487ED80;

  // atan(2^-i) in Q3.29
  localparam logic [31:0] ATAN_TAB [30] = '{
    32'h1921FB54, 32'h0ED63382, 32'h07D6DD7E, 32'h03FAB753, 32'h01FF55BB, 32'h00FFEAAD,
    32'h007FFD55, 32'h003FFFAA, 32'h001FFFF5, 32'h000FFFFE, 32'h0007FFFF, 32'h0003FFFF,
    32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF, 32'h00003FFF, 32'h00001FFF, 32'h00000FFF,
    32'h000007FF, 32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F, 32'h0000003F,
    32'h0000001F, 32'h0000000F, 32'h00000007, 32'h00000004, 32'h00000002, 32'h00000001
  };

endpackage

// File: rtl/sincos_fix2flt.sv
// Combinational Q2.30 signed fixed-point to float32 packer (mantissa truncated).
module sincos_fix2flt
  import sincos_pkg::*;
(
  input  logic signed [XY_FW-1:0] fix_i,
  output logic        [31:0]      flt_o
);

  logic        sgn;
  logic [31:0] mag;
  logic [31:0] norm;
  logic [4:0]  msb;

  // Sign/magnitude split, leading-one search, normalize and pack.
  always_comb begin
    sgn = fix_i[XY_FW-1];
    mag = sgn ? 32'(-fix_i) : 32'(fix_i);
    msb = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    norm = mag << (5'd31 - msb);
    // Value is mag * 2^-30, so the biased exponent is msb - 30 + 127.
    if (mag == '0) flt_o = '0;
    else           flt_o = {sgn, 8'(msb) + 8'd97, norm[30:8]};
  end

  logic unused_norm;
  assign unused_norm = ^{norm[31], norm[7:0]};

endmodule

// File: rtl/sincos_cordic_core.sv
// Iterative CORDIC sin/cos of a float32 angle, one micro-rotation per clock.
// Optional build macro: SINCOS_QUADRANT_FOLD_EN widens the range to |angle| <= pi by
// folding the angle into [-pi/2, pi/2] and negating cos.
module sincos_cordic_core
  import sincos_pkg::*;
#(
  parameter int unsigned ITER = 24,
  parameter int unsigned FW   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in,
  output logic        busy,
  output logic        done,
  output logic [31:0] temp_sin,
  output logic [31:0] temp_cos,
  output logic        out_range
);

  localparam int unsigned CW = $clog2(ITER) + 1;

`ifdef SINCOS_QUADRANT_FOLD_EN
  localparam logic [31:0] RANGE_LIM = PI_F32_Q329;
`else
  localparam logic [31:0] RANGE_LIM = HALF_PI_F32_Q329;
`endif

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           ang_q, ang_d;
  logic signed [FW-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic                  or_q, or_d;
  logic                  busy_q, done_q, orng_q;
  logic [31:0]           sin_q, cos_q;

  logic [7:0]            ang_exp;
  logic [31:0]           ang_man;
  logic [31:0]           ld_mag;
  logic signed [FW-1:0]  ld_z;
  logic                  ld_or;
  logic signed [FW-1:0]  x_sh, y_sh, x_it, y_it, z_it, atan_i;
  logic                  z_neg;
  logic [31:0]           sin_pk, cos_pk, cos_res;

  assign ang_exp = ang_q[30:23];
  assign ang_man = {8'h00, 1'b1, ang_q[22:0]};

`ifdef SINCOS_QUADRANT_FOLD_EN
  logic ld_cneg;
`endif

  // Float angle to Q3.29: {1,mant} scaled by 2^(exp-121), with range check and optional fold.
  always_comb begin
    ld_mag = '0;
    if (ang_exp >= 8'd121 && ang_exp <= 8'd128) begin
      ld_mag = ang_man << (ang_exp - 8'd121);
    end else if (ang_exp >= 8'd98 && ang_exp < 8'd121) begin
      ld_mag = ang_man >> (8'd121 - ang_exp);
    end
    // exp > 128 means |angle| >= 4, which never fits and is always out of range.
    ld_or = (ang_exp == 8'hFF) || (ang_exp > 8'd128) || (ld_mag > RANGE_LIM);
    ld_z  = ang_q[31] ? -ld_mag : ld_mag;
`ifdef SINCOS_QUADRANT_FOLD_EN
    ld_cneg = 1'b0;
    if (!ld_or && (ld_mag > HALF_PI_Q329)) begin
      ld_cneg = 1'b1;
      ld_z    = ang_q[31] ? (ld_mag - PI_Q329) : (PI_Q329 - ld_mag);
    end
`endif
  end

  // One micro-rotation: rotate towards z = 0 by atan(2^-i).
  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign atan_i = $signed(ATAN_TAB[cnt_q]);
  assign z_neg  = z_q[FW-1];
  assign x_it   = z_neg ? (x_q + y_sh)   : (x_q - y_sh);
  assign y_it   = z_neg ? (y_q - x_sh)   : (y_q + x_sh);
  assign z_it   = z_neg ? (z_q + atan_i) : (z_q - atan_i);

  // Next-state and datapath update for the IDLE-LOAD-ITER-PACK-DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ang_d   = ang_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    or_d    = or_q;
    case (state_q)
      StIdle: begin
        if (start && !busy_q) begin
          ang_d   = in;
          state_d = StLoad;
        end
      end
      StLoad: begin
        x_d     = CORDIC_K;
        y_d     = '0;
        z_d     = ld_z;
        or_d    = ld_or;
        cnt_d   = '0;
        state_d = StIter;
      end
      StIter: begin
        x_d = x_it;
        y_d = y_it;
        z_d = z_it;
        if (cnt_q == CW'(ITER - 1)) state_d = StPack;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      StPack:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  sincos_fix2flt u_pack_sin (.fix_i(y_q), .flt_o(sin_pk));
  sincos_fix2flt u_pack_cos (.fix_i(x_q), .flt_o(cos_pk));

`ifdef SINCOS_QUADRANT_FOLD_EN
  logic cneg_q;
  // Remember whether the angle was folded so PACK can negate cos.
  always_ff @(posedge clk) begin
    if (rst)                    cneg_q <= 1'b0;
    else if (state_q == StLoad) cneg_q <= ld_cneg;
  end
  assign cos_res = cneg_q ? {~cos_pk[31], cos_pk[30:0]} : cos_pk;
`else
  assign cos_res = cos_pk;
`endif

  // State, datapath and output registers; busy/done lag the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ang_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      or_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      orng_q  <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ang_q   <= ang_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      or_q    <= or_d;
      busy_q  <= (state_q != StIdle);
      done_q  <= (state_q == StDone);
      if (state_q == StPack) begin
        orng_q <= or_q;
        sin_q  <= or_q ? 32'h7FFFFFFF : sin_pk;
        cos_q  <= or_q ? 32'h7FFFFFFF : cos_res;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign temp_sin  = sin_q;
  assign temp_cos  = cos_q;
  assign out_range = orng_q;

endmodule

// File: tb/tb_sincos_cordic_core.sv
// Self-checking bench for sincos_cordic_core (honours SINCOS_QUADRANT_FOLD_EN).
module tb_sincos_cordic_core;

  localparam int  ITER = 24;
  localparam real TOL  = 1.0 / 1048576.0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in = '0;
  logic        busy, done, out_range;
  logic [31:0] temp_sin, temp_cos;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [31:0] res_sin, res_cos;
  logic        res_or;

  sincos_cordic_core #(.ITER(ITER), .FW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in       (in),
    .busy     (busy),
    .done     (done),
    .temp_sin (temp_sin),
    .temp_cos (temp_cos),
    .out_range(out_range)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:23] == 8'h00) return 0.0;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  function automatic bit model_or(input logic [31:0] a);
    real lim, v;
`ifdef SINCOS_QUADRANT_FOLD_EN
    lim = f2r(32'h40490FDB);
`else
    lim = f2r(32'h3FC90FDB);
`endif
    if (a[30:23] == 8'hFF) return 1'b1;
    v = f2r(a);
    if (v < 0.0) v = -v;
    return v > lim;
  endfunction

  task automatic chk_bits(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_near(input string name, input logic [31:0] act, input real exp);
    real err;
    n_checks++;
    err = f2r(act) - exp;
    if (err < 0.0) err = -err;
    if ((^act === 1'bx) || (err > TOL)) begin
      n_fail++;
      $display("FAIL %s: got %h (%f), expected %f +/- %e (t=%0t)", name, act, f2r(act),
               exp, TOL, $time);
    end
  endtask

  // Reference model: age counts edges since the accepted start, -1 when idle.
  int          m_age     = -1;
  logic [31:0] m_in      = '0;
  bit          m_cleared = 1'b1;
  bit          m_hold    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_age     <= -1;
      m_cleared <= 1'b1;
      m_hold    <= 1'b0;
    end else if (m_age < 0) begin
      if (start) begin
        m_age     <= 0;
        m_in      <= in;
        m_cleared <= 1'b0;
        m_hold    <= 1'b0;
      end
    end else if (m_age == ITER + 3) begin
      m_age <= -1;
    end else begin
      m_age <= m_age + 1;
      if (m_age + 1 == ITER + 3) m_hold <= 1'b1;
    end
  end

  // Compare DUT against the model on every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk_bits("busy", 32'(busy), 32'(m_age >= 1 && m_age <= ITER + 3));
      chk_bits("done", 32'(done), 32'(m_age == ITER + 3));
      if (m_cleared) begin
        chk_bits("sin_cleared", temp_sin, 32'h0);
        chk_bits("cos_cleared", temp_cos, 32'h0);
        chk_bits("or_cleared", 32'(out_range), 32'h0);
      end
      if (m_hold) begin
        chk_bits("out_range", 32'(out_range), 32'(model_or(m_in)));
        if (model_or(m_in)) begin
          chk_bits("sin_oor", temp_sin, 32'h7FFFFFFF);
          chk_bits("cos_oor", temp_cos, 32'h7FFFFFFF);
        end else begin
          chk_near("sin", temp_sin, $sin(f2r(m_in)));
          chk_near("cos", temp_cos, $cos(f2r(m_in)));
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] v);
    int n;
    @(negedge clk);
    in    = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < ITER + 10) begin
      @(negedge clk);
      n++;
    end
    chk_bits("latency", 32'(n), 32'(ITER + 3));
    res_sin = temp_sin;
    res_cos = temp_cos;
    res_or  = out_range;
    @(negedge clk);
  endtask

  logic [31:0] vec [14] = '{
    32'hBF000000, 32'h3F000000, 32'hBF99999A, 32'h3FC90FDC, 32'hBFC90FDB, 32'h40000000,
    32'hC0490FDB, 32'h40490FDC, 32'h40800000, 32'h7FC00000, 32'h7F800000, 32'h30000000,
    32'h00000001, 32'h3E800000
  };

  int ndone;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_bits("rst_busy", 32'(busy), 32'h0);
    chk_bits("rst_done", 32'(done), 32'h0);
    chk_bits("rst_sin", temp_sin, 32'h0);
    chk_bits("rst_cos", temp_cos, 32'h0);
    chk_bits("rst_or", 32'(out_range), 32'h0);
    chk_en = 1'b1;
    rst    = 1'b0;

    // 1.0 rad
    run_op(32'h3F800000);
    chk_near("t1_sin", res_sin, f2r(32'h3F576AA4));
    chk_near("t1_cos", res_cos, f2r(32'h3F0A5140));
    chk_bits("t1_or", 32'(res_or), 32'h0);

    // zero
    run_op(32'h00000000);
    chk_near("t2_sin", res_sin, 0.0);
    chk_near("t2_cos", res_cos, 1.0);

    // float32 pi/2
    run_op(32'h3FC90FDB);
    chk_near("t3_sin", res_sin, 1.0);
    chk_near("t3_cos", res_cos, 0.0);
    chk_bits("t3_or", 32'(res_or), 32'h0);

    // float32 pi
    run_op(32'h40490FDB);
`ifdef SINCOS_QUADRANT_FOLD_EN
    chk_bits("t4_or", 32'(res_or), 32'h0);
    chk_near("t4_sin", res_sin, 0.0);
    chk_near("t4_cos", res_cos, -1.0);
`else
    chk_bits("t4_or", 32'(res_or), 32'h1);
    chk_bits("t4_sin", res_sin, 32'h7FFFFFFF);
    chk_bits("t4_cos", res_cos, 32'h7FFFFFFF);
`endif

    foreach (vec[i]) run_op(vec[i]);

    // Starts while busy (cycles 1, 5, ITER+3) and in the DONE cycle must be ignored.
    @(negedge clk);
    in    = 32'h3F000000;
    start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 2 * ITER + 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      start = (k == 1 || k == 5 || k == ITER + 3 || k == ITER + 4);
      in    = 32'h40000000;
    end
    start = 1'b0;
    @(negedge clk);
    if (done === 1'b1) ndone++;
    chk_bits("t5_done_count", 32'(ndone), 32'h1);
    chk_near("t5_sin_held", temp_sin, 0.479425538604203);
    chk_near("t5_cos_held", temp_cos, 0.877582561890373);

    // Reset at cycle 10 of an operation.
    @(negedge clk);
    in    = 32'h3F800000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_bits("t6_busy", 32'(busy), 32'h0);
    chk_bits("t6_done", 32'(done), 32'h0);
    chk_bits("t6_sin", temp_sin, 32'h0);
    chk_bits("t6_cos", temp_cos, 32'h0);
    chk_bits("t6_or", 32'(out_range), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    run_op(32'hBF000000);
    chk_near("t6_sin_after", res_sin, -0.479425538604203);
    chk_near("t6_cos_after", res_cos, 0.877582561890373);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
